byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Upstream producer for the team's enabled-register stage (the flopenr-style capture register).
- Accepts a byte stream over a valid/ready handshake and packs BYTES = WIDTH/8 bytes into one WIDTH-bit word.
- Presents the word and drives a one-cycle `load` strobe that wires directly to the capture register's enable.
- Supports early flush with zero padding, downstream stall, and a wrapping count of emitted words.

Parameters:
- WIDTH, 32, output word width in bits; must be a multiple of 8 and at least 16.
- CW, 8, width of the emitted-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_last  input  1  final byte of a message; forces a flush; qualified by in_valid.
- in_ready  output  1  block can accept a byte this cycle.
- stall  input  1  downstream not ready; suppresses `load`.
- load  output  1  one-cycle enable to the capture register.
- word  output  WIDTH  packed word; meaningful only while load=1.
- short  output  1  word was flushed by in_last before BYTES bytes arrived; meaningful only while load=1.
- word_count  output  CW  number of words emitted, modulo 2^CW.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - On reset: state=FILL, byte index idx=0, word=0, short=0, word_count=0.
  - Outputs after reset: load=0, in_ready=1.
  - Reset mid-operation discards any partial word and any pending emit; no load pulse is produced.
- A byte is accepted when in_valid & in_ready at a rising edge.
- Byte order: the first accepted byte goes to word[WIDTH-1:WIDTH-8]; byte k goes to word[WIDTH-1-8k : WIDTH-8-8k].
- States: FILL and EMIT.
- FILL:
  - in_ready=1, load=0.
  - On accept: write in_data into slot idx, then idx <= idx+1.
  - If idx==BYTES-1 or in_last=1 on the accept: next state EMIT, idx <= 0.
  - short <= 1 if in_last caused the transition with idx<BYTES-1, else short <= 0.
  - Unwritten slots remain 0, giving zero padding in the low bytes.
- EMIT:
  - in_ready=0.
  - load = (state==EMIT) & ~stall (combinational from state and stall).
  - With stall=1: remain in EMIT; word and short held unchanged; load=0.
  - With stall=0: load=1 for exactly this cycle. At the edge: word_count <= word_count+1 (wraps at 2^CW), word <= 0, short <= 0, state <= FILL.
- Latency:
  - Last byte accepted at edge N means load=1 in the cycle following edge N, provided stall=0.
  - Minimum period is BYTES+1 cycles per word at full input rate; the EMIT cycle is a bubble with in_ready=0.
- in_valid while in EMIT is ignored (in_ready=0); upstream must hold its data.
- in_last on an accept that is also byte BYTES-1 gives a full word with short=0.
- in_last while idx=0 (single-byte message) gives word = {in_data, zeros}, short=1.
- in_data and in_last are don't-care when in_valid=0.
- stall asserted during FILL has no effect; it only gates load in EMIT.
- word_count wraps from 2^CW-1 to 0 with no flag.

Test Plan:
- Reset check: assert reset 2 cycles -> load=0, in_ready=1, word=0, word_count=0, short=0.
- Full word, WIDTH=32: feed 0x11,0x22,0x33,0x44 on consecutive cycles, stall=0 -> load=1 exactly one cycle after the 4th accept; word=0x11223344, short=0, word_count=1; in_ready=0 only during that cycle.
- Early flush: 0xAA, then 0xBB with in_last=1 -> word=0xAABB0000, short=1, single load pulse; next word starts at MSB slot.
- Stall: complete a word, hold stall=1 for 3 cycles -> load=0 and word held throughout, in_ready=0, in_valid ignored; drop stall -> one load pulse, word unchanged.
- Reset mid-word: accept 0x01,0x02, assert reset, then feed 0xDE,0xAD,0xBE,0xEF -> no load before the reset; the single load shows 0xDEADBEEF, word_count=1.
- Counter wrap, CW=2: emit 5 words back-to-back -> word_count sequence 1,2,3,0,1; in_valid gaps mid-word don't corrupt byte placement.

Source files
------------

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Packs a valid/ready byte stream into WIDTH-bit words, first byte
//            in the most significant slot. A message end (in_last) flushes a
//            partial word, leaving the unwritten low bytes as zero. Each
//            finished word is presented with a one-cycle load strobe that
//            drives the enable of the downstream capture register.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high reset
//            in_valid   - upstream byte valid
//            in_data    - upstream byte
//            in_last    - final byte of a message, qualified by in_valid
//            in_ready   - a byte can be accepted this cycle
//            stall      - downstream not ready, holds the word and gates load
//            load       - one-cycle capture enable
//            word       - packed word, meaningful while load=1
//            short      - word was flushed early, meaningful while load=1
//            word_count - number of words emitted, modulo 2^CW
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_packer #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             stall,
  output logic             load,
  output logic [WIDTH-1:0] word,
  output logic             short,
  output logic [CW-1:0]    word_count
);

  localparam int c_BYTES = WIDTH / 8;
  localparam int c_IW    = $clog2(c_BYTES);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_IW-1:0]  r_idx;
  logic [WIDTH-1:0] r_word;
  logic             r_short;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_last_slot;
  logic [WIDTH-1:0] w_byte_placed;

  assign w_accept    = in_valid & (r_state == S_FILL);
  assign w_last_slot = (r_idx == c_IW'(c_BYTES - 1));

  // Slots not yet written are zero (cleared on every emit and on reset),
  // so the incoming byte can be OR-ed into place: shift it down from the
  // MSB slot by idx bytes.
  assign w_byte_placed = {in_data, {(WIDTH-8){1'b0}}} >> {r_idx, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_word  <= '0;
      r_short <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_word <= r_word | w_byte_placed;
            if (w_last_slot || in_last) begin
              r_state <= S_EMIT;
              r_idx   <= '0;
              r_short <= ~w_last_slot;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_short <= 1'b0;
            end
          end
        end
        S_EMIT: begin
          // While stalled, everything holds; otherwise this is the load cycle.
          if (!stall) begin
            r_state <= S_FILL;
            r_word  <= '0;
            r_short <= 1'b0;
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == S_FILL);
  assign load       = (r_state == S_EMIT) & ~stall;
  assign word       = r_word;
  assign short      = r_short;
  assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_word_packer
// Purpose  : Self-checking bench for byte_word_packer. Two instances share
//            the stimulus: one with the default 8-bit word counter and one
//            with a 2-bit counter to exercise wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_word_packer;

  localparam int WIDTH = 32;
  localparam int BYTES = WIDTH / 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             stall;

  logic             in_ready8, load8, short8;
  logic [WIDTH-1:0] word8;
  logic [7:0]       wc8;
  logic             in_ready2, load2, short2;
  logic [WIDTH-1:0] word2;
  logic [1:0]       wc2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  byte_word_packer #(.WIDTH(WIDTH), .CW(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready8), .stall(stall), .load(load8),
    .word(word8), .short(short8), .word_count(wc8)
  );

  byte_word_packer #(.WIDTH(WIDTH), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready2), .stall(stall), .load(load2),
    .word(word2), .short(short2), .word_count(wc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Collect the bytes of the current word in a queue; a word is complete
  // when BYTES bytes have arrived or in_last is seen. A complete word waits
  // until a cycle with stall=0, which is its load cycle.
  byte        m_q[$];
  bit         m_emit  = 0;
  logic [WIDTH-1:0] m_word = '0;
  bit         m_short = 0;
  int         m_count = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_emit  = 0;
      m_count = 0;
      m_word  = '0;
      m_short = 0;
    end else if (m_emit) begin
      if (!stall) begin
        m_emit  = 0;
        m_count = m_count + 1;
      end
    end else if (in_valid) begin
      m_q.push_back(in_data);
      if (m_q.size() == BYTES || in_last) begin
        m_word = '0;
        for (int i = 0; i < m_q.size(); i++)
          m_word[WIDTH-1-8*i -: 8] = m_q[i];
        m_short = (m_q.size() < BYTES);
        m_q.delete();
        m_emit = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready8", 64'(in_ready8), 64'(!m_emit));
      chk("in_ready2", 64'(in_ready2), 64'(!m_emit));
      chk("load8", 64'(load8), 64'(m_emit && !stall));
      chk("load2", 64'(load2), 64'(m_emit && !stall));
      chk("word_count8", 64'(wc8), 64'(m_count % 256));
      chk("word_count2", 64'(wc2), 64'(m_count % 4));
      if (m_emit) begin
        chk("word8", 64'(word8), 64'(m_word));
        chk("word2", 64'(word2), 64'(m_word));
        chk("short8", 64'(short8), 64'(m_short));
        chk("short2", 64'(short2), 64'(m_short));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drive happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Present a byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic last);
    int tries;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tries    = 0;
    while (!in_ready8 && tries < 20) begin
      tick();
      tries++;
    end
    if (!in_ready8) chk("send_timeout", 64'(0), 64'(1));
    else            tick();
  endtask

  task automatic check_load(input string name, input logic [WIDTH-1:0] w, input logic s);
    chk({name, "_load"}, 64'(load8), 64'(1));
    chk({name, "_word"}, 64'(word8), 64'(w));
    chk({name, "_short"}, 64'(short8), 64'(s));
  endtask

  int exp_wc2 [5] = '{1, 2, 3, 0, 1};

  initial begin
    logic [WIDTH-1:0] expw;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    stall    = 1'b0;
    tick();
    chk_en = 1;
    do_reset(2);

    // Reset state
    chk("rst_load", 64'(load8), 64'(0));
    chk("rst_in_ready", 64'(in_ready8), 64'(1));
    chk("rst_word", 64'(word8), 64'(0));
    chk("rst_short", 64'(short8), 64'(0));
    chk("rst_count", 64'(wc8), 64'(0));

    // Full word
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    in_valid = 1'b0;
    check_load("full", 32'h11223344, 1'b0);
    chk("full_ready_in_emit", 64'(in_ready8), 64'(0));
    tick();
    chk("full_count", 64'(wc8), 64'(1));
    chk("full_single_pulse", 64'(load8), 64'(0));
    chk("full_ready_after", 64'(in_ready8), 64'(1));

    // Early flush, then a one-byte message lands in the MSB slot
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    in_valid = 1'b0;
    check_load("flush", 32'hAABB0000, 1'b1);
    tick();
    chk("flush_single_pulse", 64'(load8), 64'(0));
    send_byte(8'h5A, 1);
    in_valid = 1'b0;
    check_load("one_byte", 32'h5A000000, 1'b1);
    tick();

    // in_last on the final slot gives a full, non-short word
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hC4, 1);
    in_valid = 1'b0;
    check_load("last_full", 32'hC1C2C3C4, 1'b0);
    tick();

    // Stall: asserted during fill (no effect) and held 3 cycles in emit
    stall = 1'b1;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    in_data = 8'h99;  // valid byte offered while emitting is ignored
    for (int i = 0; i < 3; i++) begin
      chk("stall_load", 64'(load8), 64'(0));
      chk("stall_word", 64'(word8), 64'(32'h01020304));
      chk("stall_ready", 64'(in_ready8), 64'(0));
      tick();
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_load("stall_release", 32'h01020304, 1'b0);
    tick();
    chk("stall_count", 64'(wc8), 64'(5));

    // Reset mid-word discards the partial word
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    do_reset(1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    in_valid = 1'b0;
    check_load("after_reset", 32'hDEADBEEF, 1'b0);
    tick();
    chk("after_reset_count", 64'(wc8), 64'(1));

    // Counter wrap on the 2-bit instance, back-to-back words with gaps
    do_reset(1);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        send_byte({4'(w), 4'(b)}, 0);
        if (b == 1 && (w % 2) == 1) idle(2);
      end
      in_valid = 1'b0;
      expw = {4'(w), 4'd0, 4'(w), 4'd1, 4'(w), 4'd2, 4'(w), 4'd3};
      check_load("wrap", expw, 1'b0);
      tick();
      chk("wrap_count2", 64'(wc2), 64'(exp_wc2[w]));
      chk("wrap_count8", 64'(wc8), 64'(w + 1));
    end

    idle(3);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
